// File: rtl/window_reg_file.sv
// Windowed register file: four logical registers R0..R3 mapped onto eight
// physical registers through a 2-bit window pointer. Adjacent windows overlap
// by two registers, so R2/R3 of window w are R0/R1 of window w+1 (mod 4).
// Two combinational read ports, one synchronous write port.
module window_reg_file #(
    parameter int         WIDTH     = 16,
    parameter logic [1:0] RESET_WND = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       window,
    input  logic             ldWnd,
    input  logic             we,
    input  logic [1:0]       wAddr,
    input  logic [WIDTH-1:0] wData,
    input  logic [1:0]       rAddrA,
    input  logic [1:0]       rAddrB,
    output logic [WIDTH-1:0] rDataA,
    output logic [WIDTH-1:0] rDataB,
    output logic [1:0]       curWnd,
    output logic             wndChg
);

    // Physical storage and window state.
    logic [WIDTH-1:0] r_regs [0:7];
    logic [1:0]       r_cur_wnd;
    logic             r_wnd_chg;

    // Mapped physical indices for the write port and both read ports.
    logic [2:0] w_wr_phys;
    logic [2:0] w_rd_phys_a;
    logic [2:0] w_rd_phys_b;

    // phys = 2*window + logical, kept 3 bits wide so window 3 wraps to p0/p1.
    function automatic logic [2:0] map_phys(input logic [1:0] wnd, input logic [1:0] lreg);
        return {wnd, 1'b0} + {1'b0, lreg};
    endfunction

    assign w_wr_phys   = map_phys(r_cur_wnd, wAddr);
    assign w_rd_phys_a = map_phys(r_cur_wnd, rAddrA);
    assign w_rd_phys_b = map_phys(r_cur_wnd, rAddrB);

    // Register storage: cleared on reset, otherwise written through the pre-edge window.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data array is reset explicitly because software relies on
            // every register reading 0 after reset; this costs a reset on each flop.
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking assignment keeps the old contents visible to the
            // combinational read ports until the edge, which gives no-bypass reads.
            r_regs[w_wr_phys] <= wData;
        end
    end

    // Window pointer load and one-cycle change pulse; reset overrides any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_wnd <= RESET_WND;
            r_wnd_chg <= 1'b0;
        end else begin
            r_wnd_chg <= ldWnd && (window != r_cur_wnd);
            if (ldWnd) begin
                r_cur_wnd <= window;
            end
        end
    end

    assign rDataA = r_regs[w_rd_phys_a];
    assign rDataB = r_regs[w_rd_phys_b];
    assign curWnd = r_cur_wnd;
    assign wndChg = r_wnd_chg;

endmodule

// File: tb/tb_window_reg_file.sv
// Directed testbench for window_reg_file: reset, overlap, wrap, simultaneous
// write+load, window-change pulse and reset in the middle of activity.
module tb_window_reg_file;

    localparam int         WIDTH     = 16;
    localparam logic [1:0] RESET_WND = 2'd0;

    logic             clk;
    logic             rst;
    logic [1:0]       window;
    logic             ldWnd;
    logic             we;
    logic [1:0]       wAddr;
    logic [WIDTH-1:0] wData;
    logic [1:0]       rAddrA;
    logic [1:0]       rAddrB;
    logic [WIDTH-1:0] rDataA;
    logic [WIDTH-1:0] rDataB;
    logic [1:0]       curWnd;
    logic             wndChg;

    int checks;
    int errors;

    window_reg_file #(
        .WIDTH    (WIDTH),
        .RESET_WND(RESET_WND)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .window(window),
        .ldWnd (ldWnd),
        .we    (we),
        .wAddr (wAddr),
        .wData (wData),
        .rAddrA(rAddrA),
        .rAddrB(rAddrB),
        .rDataA(rDataA),
        .rDataB(rDataB),
        .curWnd(curWnd),
        .wndChg(wndChg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_wnd(input logic [1:0] w);
        window = w;
        ldWnd  = 1'b1;
        tick();
        ldWnd  = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [WIDTH-1:0] d);
        we    = 1'b1;
        wAddr = a;
        wData = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic set_read(input logic [1:0] a, input logic [1:0] b);
        rAddrA = a;
        rAddrB = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (curWnd !== RESET_WND) begin
            errors++;
            $display("FAIL reset_curWnd got=%0d exp=%0d", curWnd, RESET_WND);
        end
        checks++;
        if (wndChg !== 1'b0) begin
            errors++;
            $display("FAIL reset_wndChg got=%0b exp=0", wndChg);
        end
        for (int w = 0; w < 4; w++) begin
            load_wnd(w[1:0]);
            checks++;
            if (curWnd !== w[1:0]) begin
                errors++;
                $display("FAIL reset_load_w%0d got=%0d exp=%0d", w, curWnd, w);
            end
            for (int l = 0; l < 4; l++) begin
                set_read(l[1:0], 2'(3 - l));
                checks++;
                if (rDataA !== 16'h0000 || rDataB !== 16'h0000) begin
                    errors++;
                    $display("FAIL reset_read_w%0d_r%0d got A=%h B=%h exp 0000", w, l, rDataA, rDataB);
                end
            end
        end
        load_wnd(2'd0);
        tick();
    endtask

    task automatic test_overlap();
        // Read during write must still see the old value before the edge.
        we    = 1'b1;
        wAddr = 2'd2;
        wData = 16'h1234;
        set_read(2'd2, 2'd3);
        checks++;
        if (rDataA !== 16'h0000) begin
            errors++;
            $display("FAIL no_bypass got=%h exp=0000", rDataA);
        end
        tick();
        we = 1'b0;
        write_reg(2'd3, 16'hABCD);
        load_wnd(2'd1);
        checks++;
        if (wndChg !== 1'b1 || curWnd !== 2'd1) begin
            errors++;
            $display("FAIL overlap_load got wndChg=%0b curWnd=%0d exp 1/1", wndChg, curWnd);
        end
        set_read(2'd0, 2'd1);
        checks++;
        if (rDataA !== 16'h1234 || rDataB !== 16'hABCD) begin
            errors++;
            $display("FAIL overlap_read got A=%h B=%h exp 1234/abcd", rDataA, rDataB);
        end
        tick();
        checks++;
        if (wndChg !== 1'b0) begin
            errors++;
            $display("FAIL overlap_pulse_width got=%0b exp=0", wndChg);
        end
    endtask

    task automatic test_wrap();
        load_wnd(2'd3);
        write_reg(2'd2, 16'h0F0F);
        set_read(2'd2, 2'd0);
        checks++;
        if (rDataA !== 16'h0F0F || rDataB !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_w3_read got A=%h B=%h exp 0f0f/0000", rDataA, rDataB);
        end
        load_wnd(2'd0);
        set_read(2'd0, 2'd2);
        checks++;
        if (rDataA !== 16'h0F0F || rDataB !== 16'h1234) begin
            errors++;
            $display("FAIL wrap_w0_read got A=%h B=%h exp 0f0f/1234", rDataA, rDataB);
        end
        load_wnd(2'd2);
        for (int l = 0; l < 4; l++) begin
            set_read(l[1:0], l[1:0]);
            checks++;
            if (rDataA !== 16'h0000 || rDataB !== 16'h0000) begin
                errors++;
                $display("FAIL wrap_w2_r%0d got A=%h B=%h exp 0000", l, rDataA, rDataB);
            end
        end
    endtask

    task automatic test_simultaneous();
        load_wnd(2'd1);
        we     = 1'b1;
        wAddr  = 2'd1;
        wData  = 16'h5555;
        ldWnd  = 1'b1;
        window = 2'd2;
        tick();
        we     = 1'b0;
        ldWnd  = 1'b0;
        checks++;
        if (curWnd !== 2'd2) begin
            errors++;
            $display("FAIL simul_curWnd got=%0d exp=2", curWnd);
        end
        set_read(2'd0, 2'd1);
        checks++;
        if (rDataA !== 16'h0000 || rDataB !== 16'h0000) begin
            errors++;
            $display("FAIL simul_w2_read got A=%h B=%h exp 0000/0000", rDataA, rDataB);
        end
        load_wnd(2'd1);
        set_read(2'd1, 2'd0);
        checks++;
        if (rDataA !== 16'h5555 || rDataB !== 16'h1234) begin
            errors++;
            $display("FAIL simul_w1_read got A=%h B=%h exp 5555/1234", rDataA, rDataB);
        end
    endtask

    task automatic test_wndchg();
        load_wnd(2'd0);
        tick();
        load_wnd(2'd0);
        checks++;
        if (wndChg !== 1'b0 || curWnd !== 2'd0) begin
            errors++;
            $display("FAIL same_wnd got wndChg=%0b curWnd=%0d exp 0/0", wndChg, curWnd);
        end
        for (int w = 1; w < 4; w++) begin
            window = w[1:0];
            ldWnd  = 1'b1;
            tick();
            checks++;
            if (wndChg !== 1'b1 || curWnd !== w[1:0]) begin
                errors++;
                $display("FAIL b2b_w%0d got wndChg=%0b curWnd=%0d exp 1/%0d", w, wndChg, curWnd, w);
            end
        end
        ldWnd = 1'b0;
        tick();
        checks++;
        if (wndChg !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got=%0b exp=0", wndChg);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(2'd0, 16'h1111);
        write_reg(2'd1, 16'h2222);
        rst    = 1'b1;
        we     = 1'b1;
        wAddr  = 2'd0;
        wData  = 16'hFFFF;
        ldWnd  = 1'b1;
        window = 2'd2;
        tick();
        rst    = 1'b0;
        we     = 1'b0;
        ldWnd  = 1'b0;
        checks++;
        if (curWnd !== RESET_WND || wndChg !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state got curWnd=%0d wndChg=%0b exp %0d/0", curWnd, wndChg, RESET_WND);
        end
        for (int w = 0; w < 4; w++) begin
            if (w != 0) load_wnd(w[1:0]);
            for (int l = 0; l < 4; l++) begin
                set_read(l[1:0], 2'(3 - l));
                checks++;
                if (rDataA !== 16'h0000 || rDataB !== 16'h0000) begin
                    errors++;
                    $display("FAIL rst_mid_w%0d_r%0d got A=%h B=%h exp 0000", w, l, rDataA, rDataB);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        window = 2'd0;
        ldWnd  = 1'b0;
        we     = 1'b0;
        wAddr  = 2'd0;
        wData  = '0;
        rAddrA = 2'd0;
        rAddrB = 2'd0;
        tick();
        test_reset();
        test_overlap();
        test_wrap();
        test_simultaneous();
        test_wndchg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
